// File: rtl/mcb_fifo_reader.sv
// Round-robin burst drain engine for NUM_CH channel FIFOs, feeding one valid/ready stream
// through a 2-entry fall-through buffer. Define MCB_RD_PARTIAL_BURST_EN to allow short bursts.
`timescale 1ns/1ps
module mcb_fifo_reader #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  output logic [NUM_CH-1:0]                   fifo_rd_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0]        fifo_data_out,
  input  logic [NUM_CH-1:0]                   fifo_empty,
  input  logic [NUM_CH*($clog2(DEPTH)+1)-1:0] fifo_usedw,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [DATA_WIDTH-1:0]               m_data,
  output logic [$clog2(NUM_CH)-1:0]           m_ch,
  output logic                                m_first,
  output logic                                m_last
);
  localparam int UW  = $clog2(DEPTH) + 1;
  localparam int CHW = $clog2(NUM_CH);
  localparam int CW  = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [CHW-1:0]  grant_q, grant_d, last_grant_q, last_grant_d;
  logic [CW-1:0]   len_q, len_d, issued_q, issued_d, returned_q, returned_d;
  logic            inflight_q;
  logic [1:0]      occ_q, occ_d;
  logic            wr_ptr_q, rd_ptr_q;

  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic [CHW-1:0]        buf_ch_q   [2];
  logic [1:0]            buf_first_q, buf_last_q;

  logic [NUM_CH-1:0] elig_full, elig;
  logic              pick_valid;
  logic [CHW-1:0]    pick_ch, rr_idx;
  logic [CW-1:0]     pick_len;

  logic                  rd_go, pop, store;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_first, in_last;

  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    elig_full = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      elig_full[c] = !fifo_empty[c] && (fifo_usedw[c*UW +: UW] >= UW'(BURST_LEN));
    end
`ifdef MCB_RD_PARTIAL_BURST_EN
    elig = (|elig_full) ? elig_full : ~fifo_empty;
`else
    elig = elig_full;
`endif
  end

  // Search starts one past the last grant so every channel gets a turn.
  always_comb begin
    pick_valid = 1'b0;
    pick_ch    = '0;
    rr_idx     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rr_idx = CHW'((int'(last_grant_q) + 1 + i) % NUM_CH);
      if (!pick_valid && elig[rr_idx]) begin
        pick_valid = 1'b1;
        pick_ch    = rr_idx;
      end
    end
  end

`ifdef MCB_RD_PARTIAL_BURST_EN
  logic [UW-1:0] pick_usedw;

  always_comb begin
    pick_usedw = fifo_usedw[pick_ch*UW +: UW];
    if (pick_usedw >= UW'(BURST_LEN)) pick_len = CW'(BURST_LEN);
    else if (pick_usedw == '0)        pick_len = CW'(1);
    else                              pick_len = CW'(pick_usedw);
  end
`else
  assign pick_len = CW'(BURST_LEN);
`endif

  // A read is only issued when a buffer slot is reserved for its returning word.
  always_comb begin
    rd_go = (state_q == S_BURST) && (issued_q < len_q) &&
            ((3'(occ_q) + 3'(inflight_q)) < 3'd2) && !fifo_empty[grant_q];
    fifo_rd_en          = '0;
    fifo_rd_en[grant_q] = rd_go;
  end

  assign in_data  = fifo_data_out[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign in_first = (returned_q == '0);
  assign in_last  = (returned_q == len_q - CW'(1));

  // Returning word falls through to the output when the buffer is empty.
  always_comb begin
    m_valid = (occ_q != 2'd0) || inflight_q;
    m_data  = '0;
    m_ch    = '0;
    m_first = 1'b0;
    m_last  = 1'b0;
    if (occ_q != 2'd0) begin
      m_data  = buf_data_q[rd_ptr_q];
      m_ch    = buf_ch_q[rd_ptr_q];
      m_first = buf_first_q[rd_ptr_q];
      m_last  = buf_last_q[rd_ptr_q];
    end else if (inflight_q) begin
      m_data  = in_data;
      m_ch    = grant_q;
      m_first = in_first;
      m_last  = in_last;
    end
  end

  assign pop   = m_valid && m_ready;
  assign store = inflight_q && !((occ_q == 2'd0) && pop);
  assign occ_d = occ_q + 2'(inflight_q) - 2'(pop);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    len_d        = len_q;
    issued_d     = issued_q + CW'(rd_go);
    returned_d   = returned_q + CW'(inflight_q);
    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          grant_d      = pick_ch;
          last_grant_d = pick_ch;
          len_d        = pick_len;
          issued_d     = '0;
          returned_d   = '0;
          state_d      = S_BURST;
        end
      end
      S_BURST: if (issued_d == len_q) state_d = S_DRAIN;
      S_DRAIN: if ((returned_d == len_q) && (occ_d == 2'd0)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= CHW'(NUM_CH - 1);
      len_q        <= CW'(BURST_LEN);
      issued_q     <= '0;
      returned_q   <= '0;
      inflight_q   <= 1'b0;
      occ_q        <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      len_q        <= len_d;
      issued_q     <= issued_d;
      returned_q   <= returned_d;
      inflight_q   <= rd_go;
      occ_q        <= occ_d;
      if (store)                    wr_ptr_q <= ~wr_ptr_q;
      if (pop && (occ_q != 2'd0))   rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // NOTE: buffer storage is only observed while occ_q > 0, so it carries no reset.
  always_ff @(posedge clk) begin
    if (store) begin
      buf_data_q[wr_ptr_q]  <= in_data;
      buf_ch_q[wr_ptr_q]    <= grant_q;
      buf_first_q[wr_ptr_q] <= in_first;
      buf_last_q[wr_ptr_q]  <= in_last;
    end
  end

endmodule

// File: tb/tb_mcb_fifo_reader.sv
// Directed bench for mcb_fifo_reader: behavioural channel FIFOs plus an expected-word scoreboard.
`timescale 1ns/1ps
module tb_mcb_fifo_reader;
  localparam int NUM_CH = 4;
  localparam int DW     = 8;
  localparam int DEPTH  = 16;
  localparam int BL     = 4;
  localparam int UW     = $clog2(DEPTH) + 1;
  localparam int CHW    = $clog2(NUM_CH);

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_CH-1:0]      fifo_rd_en;
  logic [NUM_CH*DW-1:0]   fifo_data_out;
  logic [NUM_CH-1:0]      fifo_empty;
  logic [NUM_CH*UW-1:0]   fifo_usedw;
  logic                   m_valid;
  logic                   m_ready;
  logic [DW-1:0]          m_data;
  logic [CHW-1:0]         m_ch;
  logic                   m_first;
  logic                   m_last;

  always #5 clk = ~clk;

  mcb_fifo_reader #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .DEPTH(DEPTH), .BURST_LEN(BL)
  ) dut (
    .clk(clk), .reset(reset),
    .fifo_rd_en(fifo_rd_en), .fifo_data_out(fifo_data_out),
    .fifo_empty(fifo_empty), .fifo_usedw(fifo_usedw),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_ch(m_ch), .m_first(m_first), .m_last(m_last)
  );

  typedef struct packed {
    logic [DW-1:0]  d;
    logic [CHW-1:0] ch;
    logic           f;
    logic           l;
  } exp_t;

  exp_t sb[$];

  // Channel FIFO models: registered read data, flags updated at the clock edge.
  logic [DW-1:0]     fq [NUM_CH][$];
  logic [DW-1:0]     dout [NUM_CH] = '{default: '0};
  int                cnt_q [NUM_CH] = '{default: 0};
  logic [NUM_CH-1:0] push_en = '0;
  logic [DW-1:0]     push_data = '0;
  logic              gate = 1'b0;
  int                bad_reads = 0;

  always @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (fifo_rd_en[c]) begin
        if (fq[c].size() == 0) bad_reads <= bad_reads + 1;
        else                   dout[c] <= fq[c].pop_front();
      end
      if (push_en[c]) fq[c].push_back(push_data);
      cnt_q[c] <= fq[c].size();
    end
  end

  // While the gate is closed the DUT sees every channel as empty.
  always_comb begin
    fifo_data_out = '0;
    fifo_empty    = '1;
    fifo_usedw    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      fifo_data_out[c*DW +: DW] = dout[c];
      fifo_empty[c]             = !gate || (cnt_q[c] == 0);
      fifo_usedw[c*UW +: UW]    = gate ? UW'(cnt_q[c]) : '0;
    end
  end

  int errors = 0;
  int checks = 0;
  int outstanding = 0;
  int xfers = 0;
  logic stalled_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_words(input int ch, input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      gate          = 1'b0;
      push_en       = '0;
      push_en[ch]   = 1'b1;
      push_data     = base + DW'(i);
    end
    @(negedge clk);
    push_en = '0;
  endtask

  task automatic exp_burst(input int ch, input logic [DW-1:0] base, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.d  = base + DW'(i);
      e.ch = CHW'(ch);
      e.f  = (i == 0);
      e.l  = (i == n - 1);
      sb.push_back(e);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, then sample and score.
  task automatic cycle(input logic rdy, input logic g);
    exp_t e;
    @(negedge clk);
    m_ready = rdy;
    gate    = g;
    #1;
    check("rd_en_onehot", ($countones(fifo_rd_en) <= 1), 1);
    if (outstanding >= 2) check("rd_en_at_2_outstanding", fifo_rd_en, 0);
    if (stalled_prev) check("valid_held", m_valid, 1);
    if (m_valid) begin
      check("word_expected", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb[0];
        check("m_data", m_data, e.d);
        check("m_ch", m_ch, e.ch);
        check("m_first", m_first, e.f);
        check("m_last", m_last, e.l);
      end
    end
    if (fifo_rd_en != '0) outstanding++;
    if (m_valid && m_ready) begin
      outstanding--;
      xfers++;
      if (sb.size() > 0) void'(sb.pop_front());
    end
    stalled_prev = m_valid && !m_ready;
  endtask

  task automatic drain(input logic bp, input int budget);
    logic [3:0] pat;
    pat = 4'b1001;
    for (int j = 0; j < budget && sb.size() > 0; j++) begin
      cycle(bp ? pat[2'(j)] : 1'b1, 1'b1);
    end
    check("drain_done", sb.size(), 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    gate  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    outstanding  = 0;
    stalled_prev = 1'b0;
  endtask

  initial begin
    int x0;
    int n_rd;
    reset   = 1'b1;
    m_ready = 1'b0;

    // Reset values
    @(negedge clk);
    #1;
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_ch", m_ch, 0);
    check("rst_m_first", m_first, 0);
    check("rst_m_last", m_last, 0);
    @(negedge clk);
    reset = 1'b0;

    // Full-burst timing on channel 1
    push_words(1, 8'hA0, 4);
    exp_burst(1, 8'hA0, 4);
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 1'b1);
      check("t_rd_en", fifo_rd_en, (k >= 1 && k <= 4) ? 4'b0010 : 4'b0000);
      check("t_m_valid", m_valid, (k >= 2 && k <= 5) ? 1 : 0);
    end
    check("t_all_out", sb.size(), 0);

    // Round-robin over four full channels
    apply_reset();
    for (int c = 0; c < NUM_CH; c++) push_words(c, 8'h80 + DW'(c * 16), 8);
    for (int b = 0; b < 8; b++) exp_burst(b % NUM_CH, 8'h80 + DW'((b % NUM_CH) * 16) + DW'((b / NUM_CH) * 4), 4);
    x0 = xfers;
    drain(1'b0, 200);
    check("rr_word_count", xfers - x0, 32);

    // Backpressure with ready pattern 1,0,0,1
    push_words(0, 8'h40, 8);
    exp_burst(0, 8'h40, 4);
    exp_burst(0, 8'h44, 4);
    drain(1'b1, 200);

    // Sub-burst fill on channel 2
    push_words(2, 8'h60, 3);
`ifdef MCB_RD_PARTIAL_BURST_EN
    exp_burst(2, 8'h60, 3);
    drain(1'b0, 60);
`else
    n_rd = 0;
    for (int k = 0; k < 30; k++) begin
      cycle(1'b1, 1'b1);
      if (fifo_rd_en != '0) n_rd++;
    end
    check("sub_no_rd_en", n_rd, 0);
`endif

    // Reset after the second word of a burst
    push_words(0, 8'h50, 4);
    exp_burst(0, 8'h50, 4);
    x0 = xfers;
    for (int j = 0; j < 20 && xfers < x0 + 2; j++) cycle(1'b1, 1'b1);
    check("mid_two_words", xfers - x0, 2);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rd_en", fifo_rd_en, 0);
    check("mid_m_valid", m_valid, 0);
    check("mid_m_data", m_data, 0);
    check("mid_m_ch", m_ch, 0);
    check("mid_m_first", m_first, 0);
    check("mid_m_last", m_last, 0);
    gate = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    outstanding  = 0;
    stalled_prev = 1'b0;
    check("mid_fifo_left", fq[0].size(), 1);
    push_words(0, 8'h54, 3);
    exp_burst(0, 8'h53, 4);
    drain(1'b0, 60);

    check("no_empty_reads", bad_reads, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
